// File: rtl/eth_tx_arb.sv
// eth_tx_arb: round-robin arbiter that lends the single eth_tx byte stream
// to one of P_NUM_SRC frame sources per frame. The winner's bytes pass
// straight through, and its dst MAC and pkt type are latched at grant.
// Each frame is followed by an idle gap before the next arbitration.
module eth_tx_arb #(
  parameter int P_NUM_SRC    = 2,
  parameter int P_GAP_CYCLES = 24,
  parameter int P_MAX_BYTES  = 1514
) (
  input  logic                      tx_clk,
  input  logic                      tx_rst,
  input  logic [P_NUM_SRC-1:0]      src_vld,
  output logic [P_NUM_SRC-1:0]      src_rdy,
  input  logic [8*P_NUM_SRC-1:0]    src_byte,
  input  logic [P_NUM_SRC-1:0]      src_last,
  input  logic [48*P_NUM_SRC-1:0]   src_dst_mac,
  input  logic [16*P_NUM_SRC-1:0]   src_pkt_type,
  output logic                      tx_byte_vld,
  input  logic                      tx_byte_rdy,
  output logic [7:0]                tx_byte,
  output logic [47:0]               tx_dst_mac,
  output logic [15:0]               tx_pkt_type,
  output logic [P_NUM_SRC-1:0]      grant,
  output logic                      busy,
  output logic                      err_overrun
);

  localparam int IW = (P_NUM_SRC > 1) ? $clog2(P_NUM_SRC) : 1;
  localparam int GW = (P_GAP_CYCLES > 1) ? $clog2(P_GAP_CYCLES) : 1;
  localparam logic [10:0]   LAST_CNT = 11'(P_MAX_BYTES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(P_NUM_SRC - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(P_GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        gidx, gidx_nxt;
  logic [IW-1:0]        ptr, ptr_nxt;
  logic [10:0]          byte_cnt, byte_cnt_nxt;
  logic [GW-1:0]        gap_cnt, gap_cnt_nxt;
  logic [P_NUM_SRC-1:0] grant_nxt;
  logic [47:0]          mac_nxt;
  logic [15:0]          type_nxt;
  logic                 err_nxt;
  logic                 found;
  logic [IW-1:0]        sel;
  logic                 hs;

  assign busy = (state == XFER) || (state == GAP);
  assign hs   = (state == XFER) && src_vld[gidx] && tx_byte_rdy;

  // Pick the first requesting source at or after the round-robin pointer.
  always_comb begin
    found = 1'b0;
    sel   = ptr;
    for (int i = 0; i < P_NUM_SRC; i++) begin
      int cand;
      cand = int'(ptr) + i;
      if (cand >= P_NUM_SRC) cand = cand - P_NUM_SRC;
      if (!found && src_vld[cand]) begin
        found = 1'b1;
        sel   = IW'(cand);
      end
    end
  end

  // Byte passthrough: only the granted source sees ready, and only in XFER.
  always_comb begin
    tx_byte_vld = 1'b0;
    tx_byte     = '0;
    src_rdy     = '0;
    if (state == XFER) begin
      tx_byte_vld   = src_vld[gidx];
      tx_byte       = src_byte[8*int'(gidx) +: 8];
      src_rdy[gidx] = tx_byte_rdy;
    end
  end

  // Next-state logic: grant on request, end frame on last or byte ceiling, then gap.
  always_comb begin
    state_nxt    = state;
    gidx_nxt     = gidx;
    ptr_nxt      = ptr;
    byte_cnt_nxt = byte_cnt;
    gap_cnt_nxt  = gap_cnt;
    grant_nxt    = grant;
    mac_nxt      = tx_dst_mac;
    type_nxt     = tx_pkt_type;
    err_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt      = XFER;
          gidx_nxt       = sel;
          grant_nxt      = '0;
          grant_nxt[sel] = 1'b1;
          mac_nxt        = src_dst_mac[48*int'(sel) +: 48];
          type_nxt       = src_pkt_type[16*int'(sel) +: 16];
          byte_cnt_nxt   = '0;
        end
      end
      XFER: begin
        if (hs) begin
          byte_cnt_nxt = byte_cnt + 11'd1;
          if (src_last[gidx] || (byte_cnt == LAST_CNT)) begin
            err_nxt = !src_last[gidx];
            ptr_nxt = (gidx == LAST_IDX) ? '0 : gidx + IW'(1);
            if (P_GAP_CYCLES > 0) begin
              state_nxt   = GAP;
              gap_cnt_nxt = GAP_LOAD;
            end else begin
              state_nxt = IDLE;
              grant_nxt = '0;
            end
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end else begin
          gap_cnt_nxt = gap_cnt - GW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // State and datapath registers; reset drops any grant immediately.
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state       <= IDLE;
      gidx        <= '0;
      ptr         <= '0;
      byte_cnt    <= '0;
      gap_cnt     <= '0;
      grant       <= '0;
      tx_dst_mac  <= '0;
      tx_pkt_type <= '0;
      err_overrun <= 1'b0;
    end else begin
      state       <= state_nxt;
      gidx        <= gidx_nxt;
      ptr         <= ptr_nxt;
      byte_cnt    <= byte_cnt_nxt;
      gap_cnt     <= gap_cnt_nxt;
      grant       <= grant_nxt;
      tx_dst_mac  <= mac_nxt;
      tx_pkt_type <= type_nxt;
      err_overrun <= err_nxt;
    end
  end

endmodule

// File: tb/tb_eth_tx_arb.sv
// tb_eth_tx_arb: directed scenarios for the eth_tx round-robin arbiter.
// Sources are modelled as byte counters; a negedge monitor records the tx stream.
module tb_eth_tx_arb;
  localparam int N = 2;

  logic            tx_clk = 1'b0;
  logic            tx_rst;
  logic [N-1:0]    src_vld, src_rdy, src_last;
  logic [8*N-1:0]  src_byte;
  logic [48*N-1:0] src_dst_mac;
  logic [16*N-1:0] src_pkt_type;
  logic            tx_byte_vld, tx_byte_rdy;
  logic [7:0]      tx_byte;
  logic [47:0]     tx_dst_mac;
  logic [15:0]     tx_pkt_type;
  logic [N-1:0]    grant;
  logic            busy, err_overrun;

  eth_tx_arb #(.P_NUM_SRC(N), .P_GAP_CYCLES(24), .P_MAX_BYTES(1514)) dut (
    .tx_clk(tx_clk), .tx_rst(tx_rst),
    .src_vld(src_vld), .src_rdy(src_rdy), .src_byte(src_byte), .src_last(src_last),
    .src_dst_mac(src_dst_mac), .src_pkt_type(src_pkt_type),
    .tx_byte_vld(tx_byte_vld), .tx_byte_rdy(tx_byte_rdy), .tx_byte(tx_byte),
    .tx_dst_mac(tx_dst_mac), .tx_pkt_type(tx_pkt_type),
    .grant(grant), .busy(busy), .err_overrun(err_overrun)
  );

  always #5 tx_clk = ~tx_clk;

  localparam logic [47:0] MAC0 = 48'h02_11_22_33_44_55;
  localparam logic [47:0] MAC1 = 48'h02_AA_BB_CC_DD_EE;
  localparam logic [47:0] MACB = 48'h02_99_88_77_66_55;
  localparam logic [15:0] T0 = 16'h0800;
  localparam logic [15:0] T1 = 16'h0806;
  localparam logic [15:0] TB = 16'h86DD;

  // Source model state
  int          m_len[N]    = '{default: 0};
  int          m_frames[N] = '{default: 0};
  int          m_pos[N]    = '{default: 0};
  bit          m_last_en[N];
  logic [47:0] m_mac[N];
  logic [15:0] m_type[N];
  bit          hs_flag[N];
  bit          stall_mode = 1'b0;

  // Monitor results
  logic [7:0]   cap_q[$];
  logic [7:0]   exp_q[$];
  logic [N-1:0] gnt_q[$];
  logic [47:0]  mac_q[$];
  logic [15:0]  type_q[$];
  int busy_cnt, err_cnt, err_at, stall_viol, multi_cnt, rdy_viol;
  logic err_txv, err_busy;
  logic prev_stall = 1'b0;
  logic [7:0] prev_byte = '0;
  logic [N-1:0] prev_grant = '0;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [7:0] pat(int s, int p);
    return 8'(p * 7 + s * 97 + 3);
  endfunction

  function automatic int stream_errs();
    int e = 0;
    if (cap_q.size() != exp_q.size()) e++;
    for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++)
      if (cap_q[k] !== exp_q[k]) e++;
    return e;
  endfunction

  task automatic drive_pins();
    for (int i = 0; i < N; i++) begin
      src_vld[i]              = (m_frames[i] > 0);
      src_byte[8*i +: 8]      = pat(i, m_pos[i]);
      src_last[i]             = m_last_en[i] && (m_pos[i] == m_len[i] - 1);
      src_dst_mac[48*i +: 48] = m_mac[i];
      src_pkt_type[16*i +: 16] = m_type[i];
    end
  endtask

  // Source driver: advance on accepted bytes, then present the next byte
  initial begin
    forever begin
      @(posedge tx_clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs_flag[i] && m_frames[i] > 0) begin
          m_pos[i]++;
          if (m_pos[i] == m_len[i]) begin
            m_pos[i] = 0;
            m_frames[i]--;
          end
        end
      end
      drive_pins();
      tx_byte_rdy = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: samples settled values midway between rising edges
  always @(negedge tx_clk) begin
    for (int i = 0; i < N; i++) hs_flag[i] = src_vld[i] && src_rdy[i];
    if (tx_byte_vld && tx_byte_rdy) cap_q.push_back(tx_byte);
    if (busy) busy_cnt++;
    if (err_overrun) begin
      err_cnt++;
      if (err_cnt == 1) begin
        err_at   = cap_q.size();
        err_txv  = tx_byte_vld;
        err_busy = busy;
      end
    end
    if ($countones(grant) > 1) multi_cnt++;
    if ((src_rdy & ~grant) != '0) rdy_viol++;
    if (prev_stall && tx_byte !== prev_byte) stall_viol++;
    prev_stall = tx_byte_vld && !tx_byte_rdy;
    prev_byte  = tx_byte;
    if (grant !== prev_grant && grant !== '0) begin
      gnt_q.push_back(grant);
      mac_q.push_back(tx_dst_mac);
      type_q.push_back(tx_pkt_type);
    end
    prev_grant = grant;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(int n);
    repeat (n) begin
      @(negedge tx_clk);
      #3;
    end
  endtask

  task automatic clear_mon();
    cap_q.delete(); exp_q.delete(); gnt_q.delete(); mac_q.delete(); type_q.delete();
    busy_cnt = 0; err_cnt = 0; err_at = -1; stall_viol = 0; multi_cnt = 0; rdy_viol = 0;
    err_txv = 1'bx; err_busy = 1'bx;
  endtask

  task automatic start_src(int s, int len, int nfr, bit last_en, logic [47:0] mac, logic [15:0] typ);
    m_len[s] = len; m_frames[s] = nfr; m_pos[s] = 0;
    m_last_en[s] = last_en; m_mac[s] = mac; m_type[s] = typ;
  endtask

  task automatic wait_idle(int max, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max; c++) begin
      tick(1);
      if (m_frames[0] == 0 && m_frames[1] == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_bytes(int n, int max, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max; c++) begin
      tick(1);
      if (cap_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    tx_rst = 1'b1;
    tick(3);
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_grant: got %b want 00", grant); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (err_overrun !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_err: got %b want 0", err_overrun); end
    n_cmp++; if (tx_dst_mac !== 48'h0) begin n_bad++; $display("[TB] FAIL reset_mac: got %h want 0", tx_dst_mac); end
    n_cmp++; if (tx_pkt_type !== 16'h0) begin n_bad++; $display("[TB] FAIL reset_type: got %h want 0", tx_pkt_type); end
    n_cmp++; if (tx_byte_vld !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_txvld: got %b want 0", tx_byte_vld); end
    n_cmp++; if (src_rdy !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_srcrdy: got %b want 00", src_rdy); end
    tx_rst = 1'b0;
    tick(2);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_frame();
    bit ok;
    int e;
    clear_mon();
    start_src(0, 60, 1, 1'b1, MAC0, T0);
    for (int k = 0; k < 60; k++) exp_q.push_back(pat(0, k));
    tick(1);
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("[TB] FAIL single_early_grant: got %b want 00", grant); end
    tick(1);
    n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("[TB] FAIL single_grant: got %b want 01", grant); end
    n_cmp++; if (tx_dst_mac !== MAC0) begin n_bad++; $display("[TB] FAIL single_mac: got %h want %h", tx_dst_mac, MAC0); end
    n_cmp++; if (tx_pkt_type !== T0) begin n_bad++; $display("[TB] FAIL single_type: got %h want %h", tx_pkt_type, T0); end
    wait_idle(300, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("[TB] FAIL single_timeout: got %b want 1", ok); end
    n_cmp++; if (busy_cnt !== 84) begin n_bad++; $display("[TB] FAIL single_busy_len: got %0d want 84", busy_cnt); end
    e = stream_errs();
    n_cmp++; if (e !== 0) begin n_bad++; $display("[TB] FAIL single_stream: %0d errors, got %0d bytes want 60", e, cap_q.size()); end
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("[TB] FAIL single_grant_end: got %b want 00", grant); end
    n_cmp++; if (err_cnt !== 0) begin n_bad++; $display("[TB] FAIL single_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int e;
    tx_rst = 1'b1;
    tick(2);
    tx_rst = 1'b0;
    tick(1);
    clear_mon();
    start_src(0, 8, 2, 1'b1, MAC0, T0);
    start_src(1, 8, 1, 1'b1, MAC1, T1);
    for (int k = 0; k < 8; k++) exp_q.push_back(pat(0, k));
    for (int k = 0; k < 8; k++) exp_q.push_back(pat(1, k));
    for (int k = 0; k < 8; k++) exp_q.push_back(pat(0, k));
    wait_idle(600, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("[TB] FAIL rr_timeout: got %b want 1", ok); end
    n_cmp++; if (gnt_q.size() !== 3 || {gnt_q[0], gnt_q[1], gnt_q[2]} !== 6'b01_10_01) begin
      n_bad++; $display("[TB] FAIL rr_order: got %0d grants %b %b %b want 01 10 01", gnt_q.size(), gnt_q[0], gnt_q[1], gnt_q[2]);
    end
    n_cmp++; if ({mac_q[0], mac_q[1], mac_q[2]} !== {MAC0, MAC1, MAC0}) begin
      n_bad++; $display("[TB] FAIL rr_mac: got %h %h %h want %h %h %h", mac_q[0], mac_q[1], mac_q[2], MAC0, MAC1, MAC0);
    end
    n_cmp++; if (multi_cnt !== 0) begin n_bad++; $display("[TB] FAIL rr_multi_grant: got %0d want 0", multi_cnt); end
    n_cmp++; if (rdy_viol !== 0) begin n_bad++; $display("[TB] FAIL rr_rdy_other: got %0d want 0", rdy_viol); end
    e = stream_errs();
    n_cmp++; if (e !== 0) begin n_bad++; $display("[TB] FAIL rr_stream: %0d errors, got %0d bytes want 24", e, cap_q.size()); end
  endtask

  task automatic test_stall();
    bit ok;
    int e;
    clear_mon();
    stall_mode = 1'b1;
    start_src(0, 100, 1, 1'b1, MAC0, T0);
    for (int k = 0; k < 100; k++) exp_q.push_back(pat(0, k));
    wait_idle(2000, ok);
    stall_mode = 1'b0;
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("[TB] FAIL stall_timeout: got %b want 1", ok); end
    e = stream_errs();
    n_cmp++; if (e !== 0) begin n_bad++; $display("[TB] FAIL stall_stream: %0d errors, got %0d bytes want 100", e, cap_q.size()); end
    n_cmp++; if (stall_viol !== 0) begin n_bad++; $display("[TB] FAIL stall_byte_hold: got %0d changes want 0", stall_viol); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    clear_mon();
    start_src(1, 60, 1, 1'b1, MAC1, T1);
    wait_bytes(20, 200, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_mid_timeout: got %b want 1", ok); end
    tx_rst = 1'b1;
    #1;
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("[TB] FAIL rst_mid_grant: got %b want 00", grant); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_mid_busy: got %b want 0", busy); end
    n_cmp++; if (tx_byte_vld !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_mid_txvld: got %b want 0", tx_byte_vld); end
    n_cmp++; if (src_rdy !== 2'b00) begin n_bad++; $display("[TB] FAIL rst_mid_srcrdy: got %b want 00", src_rdy); end
    n_cmp++; if (tx_dst_mac !== 48'h0 || tx_pkt_type !== 16'h0) begin
      n_bad++; $display("[TB] FAIL rst_mid_mac_type: got %h/%h want 0/0", tx_dst_mac, tx_pkt_type);
    end
    m_frames[0] = 0;
    m_frames[1] = 0;
    tick(2);
    clear_mon();
    start_src(0, 5, 1, 1'b1, MAC0, T0);
    start_src(1, 5, 1, 1'b1, MAC1, T1);
    tick(1);
    tx_rst = 1'b0;
    wait_idle(300, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_mid_idle: got %b want 1", ok); end
    n_cmp++; if (gnt_q.size() !== 2 || {gnt_q[0], gnt_q[1]} !== 4'b01_10) begin
      n_bad++; $display("[TB] FAIL rst_mid_order: got %0d grants %b %b want 01 10", gnt_q.size(), gnt_q[0], gnt_q[1]);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    int e;
    clear_mon();
    start_src(0, 1600, 1, 1'b1, MAC0, T0);
    for (int k = 0; k < 1600; k++) exp_q.push_back(pat(0, k));
    wait_bytes(1514, 2000, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("[TB] FAIL ovr_timeout: got %b want 1", ok); end
    tick(1);
    n_cmp++; if (err_at !== 1514) begin n_bad++; $display("[TB] FAIL ovr_err_pos: got %0d want 1514", err_at); end
    n_cmp++; if (err_txv !== 1'b0 || err_busy !== 1'b1) begin
      n_bad++; $display("[TB] FAIL ovr_gap: got txvld=%b busy=%b want 0 1", err_txv, err_busy);
    end
    n_cmp++; if (tx_dst_mac !== MAC0) begin n_bad++; $display("[TB] FAIL ovr_mac_first: got %h want %h", tx_dst_mac, MAC0); end
    m_mac[0]  = MACB;
    m_type[0] = TB;
    wait_idle(600, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("[TB] FAIL ovr_idle: got %b want 1", ok); end
    n_cmp++; if (err_cnt !== 1) begin n_bad++; $display("[TB] FAIL ovr_err_count: got %0d want 1", err_cnt); end
    n_cmp++; if (gnt_q.size() !== 2 || {gnt_q[0], gnt_q[1]} !== 4'b01_01) begin
      n_bad++; $display("[TB] FAIL ovr_regrant: got %0d grants %b %b want 01 01", gnt_q.size(), gnt_q[0], gnt_q[1]);
    end
    n_cmp++; if (mac_q[1] !== MACB || type_q[1] !== TB) begin
      n_bad++; $display("[TB] FAIL ovr_new_mac: got %h/%h want %h/%h", mac_q[1], type_q[1], MACB, TB);
    end
    e = stream_errs();
    n_cmp++; if (e !== 0) begin n_bad++; $display("[TB] FAIL ovr_stream: %0d errors, got %0d bytes want 1600", e, cap_q.size()); end
  endtask

  task automatic test_mac_hold();
    bit ok;
    int e;
    clear_mon();
    start_src(1, 30, 1, 1'b1, MAC1, T1);
    for (int k = 0; k < 30; k++) exp_q.push_back(pat(1, k));
    wait_bytes(10, 200, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("[TB] FAIL hold_timeout: got %b want 1", ok); end
    m_mac[1]  = MACB;
    m_type[1] = TB;
    tick(3);
    n_cmp++; if (grant !== 2'b10) begin n_bad++; $display("[TB] FAIL hold_grant: got %b want 10", grant); end
    n_cmp++; if (tx_dst_mac !== MAC1) begin n_bad++; $display("[TB] FAIL hold_mac: got %h want %h", tx_dst_mac, MAC1); end
    n_cmp++; if (tx_pkt_type !== T1) begin n_bad++; $display("[TB] FAIL hold_type: got %h want %h", tx_pkt_type, T1); end
    wait_idle(300, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("[TB] FAIL hold_idle: got %b want 1", ok); end
    e = stream_errs();
    n_cmp++; if (e !== 0) begin n_bad++; $display("[TB] FAIL hold_stream: %0d errors, got %0d bytes want 30", e, cap_q.size()); end
  endtask

  initial begin
    tx_rst      = 1'b1;
    tx_byte_rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_last_en[i] = 1'b0;
      m_mac[i]     = '0;
      m_type[i]    = '0;
      hs_flag[i]   = 1'b0;
    end
    drive_pins();
    clear_mon();
    test_reset();
    test_single_frame();
    test_round_robin();
    test_stall();
    test_reset_midframe();
    test_overrun();
    test_mac_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
